// File: rtl/tx_frame_scheduler.sv
// tx_frame_scheduler
// Shares one UART transmit path among NREQ requesters using round-robin
// arbitration. The byte and frame configuration of the granted requester are
// captured and presented to the transmitter. The block then issues a one-cycle
// start pulse and waits for the frame-complete pulse. After each frame it holds
// off the next grant for GAP_CYCLES idle cycles.
//
// Ports
//   Clock, Reset          : rising-edge clock, asynchronous active-high reset
//   ReqValid/ReqData/...  : per-requester request, byte and frame configuration
//   ReqAck, ReqDone       : one-hot pulses for frame captured / frame finished
//   TxData/TxParityType/TxStopBits/TxDataLength : captured frame to the transmitter
//   TxSend                : one-cycle start pulse to the transmitter
//   TxActive, TxDone      : transmitter busy level and frame-complete pulse
//   Busy                  : scheduler not idle
//   GrantId               : index of the most recently granted requester
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting for a request while the transmitter is free
// LOAD      | frame captured, acknowledge the granted requester
// SEND      | start pulse to the transmitter
// WAIT_DONE | transmitter running, waiting for its done pulse
// GAP       | idle gap enforced between frames

module tx_frame_scheduler #(
   parameter int NREQ       = 4,
   parameter int GAP_CYCLES = 16,
   parameter int IW         = $clog2(NREQ)
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic [NREQ-1:0]   ReqValid,
   input  logic [8*NREQ-1:0] ReqData,
   input  logic [2*NREQ-1:0] ReqParityType,
   input  logic [NREQ-1:0]   ReqStopBits,
   input  logic [NREQ-1:0]   ReqDataLength,
   output logic [NREQ-1:0]   ReqAck,
   output logic [NREQ-1:0]   ReqDone,
   output logic [7:0]        TxData,
   output logic [1:0]        TxParityType,
   output logic              TxStopBits,
   output logic              TxDataLength,
   output logic              TxSend,
   input  logic              TxActive,
   input  logic              TxDone,
   output logic              Busy,
   output logic [IW-1:0]     GrantId
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD      = 3'd1,
      SEND      = 3'd2,
      WAIT_DONE = 3'd3,
      GAP       = 3'd4
   } state_t;

   localparam logic [15:0] GAP_LOAD = 16'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   state_t          state, nextState;
   logic [15:0]     gapCnt;
   logic            grantHit;
   logic [IW-1:0]   grantIdx;
   logic [NREQ-1:0] grantOneHot;
   logic [7:0]      selData;
   logic [1:0]      selParity;
   logic            selStop;
   logic            selLength;
   logic            capture;
   logic            frameDone;

   // Round-robin search starts one past the last grant and wraps.
   always_comb begin
      int cand;
      cand     = 0;
      grantHit = 1'b0;
      grantIdx = GrantId;
      for (int k = 1; k <= NREQ; k++) begin
         cand = int'(GrantId) + k;
         if (cand >= NREQ) cand = cand - NREQ;
         if (!grantHit && ReqValid[IW'(cand)]) begin
            grantHit = 1'b1;
            grantIdx = IW'(cand);
         end
      end
   end

   always_comb begin
      selData   = '0;
      selParity = '0;
      selStop   = 1'b0;
      selLength = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (grantIdx == IW'(i)) begin
            selData   = ReqData[8*i +: 8];
            selParity = ReqParityType[2*i +: 2];
            selStop   = ReqStopBits[i];
            selLength = ReqDataLength[i];
         end
      end
   end

   always_comb begin
      grantOneHot = '0;
      for (int i = 0; i < NREQ; i++) begin
         grantOneHot[i] = (GrantId == IW'(i));
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) state <= IDLE;
      else       state <= nextState;
   end

   always_comb begin
      nextState = state;
      capture   = 1'b0;
      frameDone = 1'b0;
      ReqAck    = '0;
      TxSend    = 1'b0;
      Busy      = (state != IDLE);
      case (state)
         IDLE: begin
            if (!TxActive && grantHit) begin
               capture   = 1'b1;
               nextState = LOAD;
            end
         end
         LOAD: begin
            ReqAck    = grantOneHot;
            nextState = SEND;
         end
         SEND: begin
            TxSend    = 1'b1;
            nextState = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (TxDone) begin
               frameDone = 1'b1;
               nextState = (GAP_CYCLES > 0) ? GAP : IDLE;
            end
         end
         GAP: begin
            if (gapCnt == 16'd0) nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         gapCnt       <= '0;
         GrantId      <= IW'(NREQ - 1);
         TxData       <= '0;
         TxParityType <= '0;
         TxStopBits   <= 1'b0;
         TxDataLength <= 1'b0;
         ReqDone      <= '0;
      end else begin
         ReqDone <= frameDone ? grantOneHot : '0;
         if (frameDone) begin
            gapCnt <= GAP_LOAD;
         end else if (state == GAP && gapCnt != 16'd0) begin
            gapCnt <= gapCnt - 16'd1;
         end
         if (capture) begin
            GrantId      <= grantIdx;
            // 7-bit frames never carry bit 7 to the frame generator.
            TxData       <= {selData[7] & selLength, selData[6:0]};
            TxParityType <= selParity;
            TxStopBits   <= selStop;
            TxDataLength <= selLength;
         end
      end
   end

endmodule

// File: doc/tx_frame_scheduler.md
# tx_frame_scheduler

Round-robin scheduler that shares the single UART transmit path (frame generator, parity unit and shift-out stage) among `NREQ` independent requesters. It captures one byte and its frame configuration from the granted requester and presents them to the transmitter. It issues a one-cycle start pulse, waits for the transmitter's done pulse, then enforces a programmable idle gap before the next grant. It sits between the client-side byte sources and the UART-Tx top.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `GAP_CYCLES`, 16: idle clock cycles inserted after each completed frame, 0..65535.
- `IW`, `$clog2(NREQ)`: width of `GrantId`.

- `Clock` in 1: single clock; all state on its rising edge.
- `Reset` in 1: asynchronous, active-high reset.
- `ReqValid` in NREQ: per-requester request. Held with data until acknowledged.
- `ReqData` in 8*NREQ: requester i byte at [8i+7:8i].
- `ReqParityType` in 2*NREQ: requester i parity mode at [2i+1:2i]. 00/11 means none, 01 means odd, 10 means even; passed through unchanged.
- `ReqStopBits` in NREQ: 0 means 1 stop bit, 1 means 2 stop bits.
- `ReqDataLength` in NREQ: 0 means 7 data bits, 1 means 8 data bits.
- `ReqAck` out NREQ: one-hot, one-cycle pulse when requester i's frame has been captured.
- `ReqDone` out NREQ: one-hot, one-cycle pulse when requester i's frame finished transmitting.
- `TxData` out 8: captured byte to the frame generator.
- `TxParityType` out 2, `TxStopBits` out 1, `TxDataLength` out 1: captured configuration.
- `TxSend` out 1: one-cycle start pulse to the transmitter.
- `TxActive` in 1: transmitter busy (level).
- `TxDone` in 1: transmitter frame-complete pulse.
- `Busy` out 1: high in every state except IDLE.
- `GrantId` out IW: index of the last granted requester.

## Operation
- The FSM states are IDLE, LOAD, SEND, WAIT_DONE and GAP.
- **IDLE**
  - If `TxActive`=0 and any `ReqValid` is set, grant the first set bit searching from `GrantId+1` upward, wrapping modulo NREQ.
  - On the grant, capture that requester's data and configuration into the `Tx*` registers and set `GrantId` to the granted index.
  - Transition to LOAD.
  - While `TxActive`=1, no grant is made.
- **LOAD**: `ReqAck[GrantId]`=1 for this cycle only; the `Tx*` outputs are stable. Transition to SEND.
- **SEND**: `TxSend`=1 for this cycle only. Transition to WAIT_DONE.
- **WAIT_DONE**
  - On `TxDone`=1: pulse `ReqDone[GrantId]` next cycle.
  - If `GAP_CYCLES`>0, load the gap counter with `GAP_CYCLES-1` and go to GAP; otherwise go to IDLE.
- **GAP**: decrement the counter each cycle. At 0, go to IDLE.
- Data masking: if the captured `ReqDataLength`=0, `TxData[7]` is forced to 0; bits [6:0] are passed unchanged.
- `Tx*` registers hold their values from capture until the next capture.
- `TxDone` is ignored in every state other than WAIT_DONE.
- `ReqValid` of non-granted requesters is never acknowledged, dropped or reordered. Round-robin guarantees each waiting requester is served within NREQ frames.
- Requesters must deassert `ReqValid`, or present a new byte, after `ReqAck`. A still-asserted `ReqValid` at the next IDLE counts as a new request.

## Timing
- **Reset values** (asynchronous; effective immediately):
  - State IDLE, gap counter 0.
  - `GrantId`=NREQ-1, so requester 0 has first priority.
  - `TxData`=0, `TxParityType`=0, `TxStopBits`=0, `TxDataLength`=0.
  - `TxSend`=0, `ReqAck`=0, `ReqDone`=0, `Busy`=0.
- **Grant latency**: request sampled at edge E0 (in IDLE), then:
  - after E0: LOAD and `ReqAck` high;
  - after E1: `TxSend` high;
  - after E2: WAIT_DONE.
- **Done latency**: `TxDone` sampled at edge Ek; `ReqDone` is high for the cycle after Ek.
- **Gap**: GAP lasts exactly `GAP_CYCLES` cycles, then IDLE lasts at least one cycle. The minimum `TxDone`-to-next-`TxSend` spacing is `GAP_CYCLES`+3 edges.
- **Simultaneous requests**: exactly one grant per IDLE evaluation, chosen by the round-robin rule.
- **Late request**: a `ReqValid` that rises while the FSM is in GAP is sampled at the first IDLE cycle.
- **Reset mid-frame**: the FSM aborts to IDLE; no `ReqDone` is issued, and any pending `TxSend`/`ReqAck` are cleared.
- **Stuck transmitter**: if `TxDone` never arrives, the FSM stays in WAIT_DONE indefinitely with `Busy`=1 (no timeout).

## Test plan
- **Single request, GAP_CYCLES=4**: after reset, requester 2 presents 0xA5, 8 data bits, parity 01, 1 stop bit.
  - `ReqAck`=0100 one cycle after the request is sampled.
  - `TxSend` one cycle later; `TxData`=0xA5, `TxParityType`=01.
  - `TxDone` gives `ReqDone`=0100 next cycle, then exactly 4 GAP cycles, then IDLE.
- **Fairness**: all four requesters held valid for 8 frames. Grant order is 0,1,2,3,0,1,2,3, with one `ReqAck` and one `ReqDone` per frame.
- **7-bit masking**: byte 0xFF with `DataLength`=0 and 2 stop bits gives `TxData`=0x7F and `TxStopBits`=1.
- **Busy transmitter**: `TxActive`=1 while requester 1 is valid gives no `ReqAck`. The grant occurs the cycle after `TxActive` falls.
- **Spurious and late events**:
  - `TxDone` pulsed in IDLE, LOAD and SEND has no effect.
  - `ReqValid` rising during GAP is served after GAP; with `GAP_CYCLES`=0, IDLE follows WAIT_DONE directly.
- **Reset mid-frame**: `Reset` asserted in WAIT_DONE gives all outputs reset values immediately, `GrantId`=NREQ-1, and no `ReqDone`. The next request from requester 0 is granted first.
